// File: rtl/rr_dispatch_pkg.sv
// Shared types and constants for the two-output round-robin dispatcher.
package rr_dispatch_pkg;

  typedef enum logic {
    TGT_A = 1'b0,
    TGT_B = 1'b1
  } tgt_t;

  localparam int unsigned BUF_DEPTH = 2;
  localparam tgt_t        TGT_RESET = TGT_B;

endpackage

// File: rtl/rr_dispatch_buf.sv
// Two-entry registered FIFO for one dispatcher output; the head entry sits in slot 0.
module rr_dispatch_buf
  import rr_dispatch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ent_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] ent_d [BUF_DEPTH];
  logic                  pop, push_ok, wr_sel;

  assign full_o  = (cnt_q == 2'(BUF_DEPTH));
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = ent_q[0];
  assign pop     = valid_o & ready_i;
  assign push_ok = push_i & ~full_o;
  // Write slot is the occupancy left after this cycle's pop.
  assign wr_sel  = ((cnt_q - {1'b0, pop}) != 2'd0);

  // Vacated slots are cleared so an empty buffer presents zero data.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop};
    if (pop) begin
      ent_d[0] = ent_q[1];
      ent_d[1] = '0;
    end
    if (push_ok) ent_d[wr_sel] = data_i;
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      cnt_q <= '0;
      ent_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin split of one valid/ready stream onto ports A and B with per-port buffering.
// Optional per-port dispatch counters are enabled by defining RR_DISPATCH_CNT_EN.
module rr_dispatcher
  import rr_dispatch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  A_valid_o,
  input  logic                  A_ready_i,
  output logic [DATA_WIDTH-1:0] A_data_o,
  output logic                  B_valid_o,
  input  logic                  B_ready_i,
  output logic [DATA_WIDTH-1:0] B_data_o
`ifdef RR_DISPATCH_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  A_cnt_o,
  output logic [CNT_WIDTH-1:0]  B_cnt_o
`endif
);

  tgt_t last_tgt_q, last_tgt_d;
  tgt_t pref, sel;
  logic a_full, b_full;
  logic xfer, push_a, push_b;

  assign in_ready_o = ~(a_full & b_full);
  assign xfer       = in_valid_i & in_ready_o;
  assign push_a     = xfer & (sel == TGT_A);
  assign push_b     = xfer & (sel == TGT_B);

  always_comb begin
    pref = tgt_t'(~last_tgt_q);
    sel  = pref;
    if ((pref == TGT_A && a_full) || (pref == TGT_B && b_full))
      sel = tgt_t'(~pref);
    last_tgt_d = xfer ? sel : last_tgt_q;
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) last_tgt_q <= TGT_RESET;
    else            last_tgt_q <= last_tgt_d;
  end

  rr_dispatch_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf_a (
    .aclk     (aclk),
    .areset_n (areset_n),
    .push_i   (push_a),
    .data_i   (in_data_i),
    .full_o   (a_full),
    .valid_o  (A_valid_o),
    .ready_i  (A_ready_i),
    .data_o   (A_data_o)
  );

  rr_dispatch_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf_b (
    .aclk     (aclk),
    .areset_n (areset_n),
    .push_i   (push_b),
    .data_i   (in_data_i),
    .full_o   (b_full),
    .valid_o  (B_valid_o),
    .ready_i  (B_ready_i),
    .data_o   (B_data_o)
  );

`ifdef RR_DISPATCH_CNT_EN
  logic [CNT_WIDTH-1:0] a_cnt_q, b_cnt_q;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (push_a) a_cnt_q <= a_cnt_q + 1'b1;
      if (push_b) b_cnt_q <= b_cnt_q + 1'b1;
    end
  end

  assign A_cnt_o = a_cnt_q;
  assign B_cnt_o = b_cnt_q;
`endif

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed vector bench for rr_dispatcher; counter checks apply when RR_DISPATCH_CNT_EN is defined.
module tb_rr_dispatcher;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          in_valid_i, in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          A_valid_o, A_ready_i;
  logic [DW-1:0] A_data_o;
  logic          B_valid_o, B_ready_i;
  logic [DW-1:0] B_data_o;
`ifdef RR_DISPATCH_CNT_EN
  logic [CW-1:0] A_cnt_o, B_cnt_o;
`endif

  rr_dispatcher #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .A_valid_o  (A_valid_o),
    .A_ready_i  (A_ready_i),
    .A_data_o   (A_data_o),
    .B_valid_o  (B_valid_o),
    .B_ready_i  (B_ready_i),
    .B_data_o   (B_data_o)
`ifdef RR_DISPATCH_CNT_EN
    ,
    .A_cnt_o    (A_cnt_o),
    .B_cnt_o    (B_cnt_o)
`endif
  );

  always #5 aclk = ~aclk;

  // Inputs applied for one cycle, and outputs expected during that cycle (before its edge).
  typedef struct {
    logic          rst_n;
    logic          iv;
    logic [DW-1:0] d;
    logic          ar;
    logic          br;
    logic          ir;
    logic          av;
    logic [DW-1:0] ad;
    logic          bv;
    logic [DW-1:0] bd;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic rst_n, logic iv, logic [DW-1:0] d, logic ar, logic br,
                              logic ir, logic av, logic [DW-1:0] ad, logic bv, logic [DW-1:0] bd);
    vec_t v;
    v.rst_n = rst_n; v.iv = iv; v.d = d; v.ar = ar; v.br = br;
    v.ir = ir; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    areset_n = 1'b0; in_valid_i = 1'b0; in_data_i = '0; A_ready_i = 1'b0; B_ready_i = 1'b0;
    repeat (2) @(posedge aclk);

    //                rst iv  d       ar br   ir av ad      bv bd
    // alternation, no backpressure
    tbl.push_back(mk(1, 1, 16'h0001, 1, 1,  1, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0002, 1, 1,  1, 1, 16'h0001, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0003, 1, 1,  1, 0, 16'h0000, 1, 16'h0002));
    tbl.push_back(mk(1, 1, 16'h0004, 1, 1,  1, 1, 16'h0003, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0005, 1, 1,  1, 0, 16'h0000, 1, 16'h0004));
    tbl.push_back(mk(1, 1, 16'h0006, 1, 1,  1, 1, 16'h0005, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'hdead, 1, 1,  1, 0, 16'h0000, 1, 16'h0006));
    tbl.push_back(mk(1, 0, 16'hbeef, 0, 0,  1, 0, 16'h0000, 0, 16'h0000));
    // B stalled; includes push+pop on A at count 1 (0x14 out, 0x15 in)
    tbl.push_back(mk(1, 1, 16'h0010, 1, 0,  1, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0011, 1, 0,  1, 1, 16'h0010, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0012, 1, 0,  1, 0, 16'h0000, 1, 16'h0011));
    tbl.push_back(mk(1, 1, 16'h0013, 1, 0,  1, 1, 16'h0012, 1, 16'h0011));
    tbl.push_back(mk(1, 1, 16'h0014, 1, 0,  1, 0, 16'h0000, 1, 16'h0011));
    tbl.push_back(mk(1, 1, 16'h0015, 1, 0,  1, 1, 16'h0014, 1, 16'h0011));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0,  1, 1, 16'h0015, 1, 16'h0011));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 1, 16'h0011));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1,  1, 0, 16'h0000, 1, 16'h0011));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1,  1, 0, 16'h0000, 1, 16'h0013));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000));
    // both stalled: four accepted, fifth waits until A pops once
    tbl.push_back(mk(1, 1, 16'h0020, 0, 0,  1, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0021, 0, 0,  1, 1, 16'h0020, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0022, 0, 0,  1, 1, 16'h0020, 1, 16'h0021));
    tbl.push_back(mk(1, 1, 16'h0023, 0, 0,  1, 1, 16'h0020, 1, 16'h0021));
    tbl.push_back(mk(1, 1, 16'h0024, 0, 0,  0, 1, 16'h0020, 1, 16'h0021));
    tbl.push_back(mk(1, 1, 16'h0024, 1, 0,  0, 1, 16'h0020, 1, 16'h0021));
    tbl.push_back(mk(1, 1, 16'h0024, 0, 0,  1, 1, 16'h0022, 1, 16'h0021));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0,  0, 1, 16'h0022, 1, 16'h0021));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0,  1, 1, 16'h0024, 1, 16'h0021));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 1, 16'h0021));
    // reset mid-stream with both buffers occupied; beat offered during reset is dropped
    tbl.push_back(mk(1, 1, 16'h0030, 0, 0,  1, 0, 16'h0000, 1, 16'h0021));
    tbl.push_back(mk(0, 1, 16'h0031, 0, 0,  1, 1, 16'h0030, 1, 16'h0021));
    tbl.push_back(mk(1, 1, 16'h0032, 0, 0,  1, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,  1, 1, 16'h0032, 0, 16'h0000));

    foreach (tbl[i]) begin
      @(negedge aclk);
      areset_n = tbl[i].rst_n; in_valid_i = tbl[i].iv; in_data_i = tbl[i].d;
      A_ready_i = tbl[i].ar;   B_ready_i = tbl[i].br;
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready_o), 32'(tbl[i].ir));
      chk($sformatf("v%0d.A_valid",  i), 32'(A_valid_o),  32'(tbl[i].av));
      chk($sformatf("v%0d.A_data",   i), 32'(A_data_o),   32'(tbl[i].ad));
      chk($sformatf("v%0d.B_valid",  i), 32'(B_valid_o),  32'(tbl[i].bv));
      chk($sformatf("v%0d.B_data",   i), 32'(B_data_o),   32'(tbl[i].bd));
    end

    // A stalled holding 0x32: head must stay stable, then drain within a bounded wait
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      in_valid_i = 1'b0; A_ready_i = 1'b0; #1;
      chk("hold.A_valid", 32'(A_valid_o), 32'd1);
      chk("hold.A_data",  32'(A_data_o),  32'h32);
    end
    @(negedge aclk);
    A_ready_i = 1'b1;
    begin
      int n;
      n = 0;
      while (A_valid_o && n < 5) begin
        @(negedge aclk);
        n++;
      end
      chk("drain.A_valid_timeout", 32'(A_valid_o), 32'd0);
      chk("drain.cycles", 32'(n), 32'd1);
    end

`ifdef RR_DISPATCH_CNT_EN
    @(negedge aclk);
    areset_n = 1'b0; in_valid_i = 1'b0; A_ready_i = 1'b1; B_ready_i = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1; #1;
    chk("cnt.rst_A", 32'(A_cnt_o), 32'd0);
    chk("cnt.rst_B", 32'(B_cnt_o), 32'd0);
    // 19 beats: 2 fill B, 17 land on A -> A wraps to 1 at 4 bits
    for (int i = 0; i < 19; i++) begin
      in_valid_i = 1'b1; in_data_i = 16'(16'h0100 + i); #1;
      chk($sformatf("cnt.in_ready%0d", i), 32'(in_ready_o), 32'd1);
      @(negedge aclk);
    end
    in_valid_i = 1'b0; #1;
    chk("cnt.wrap_A", 32'(A_cnt_o), 32'd1);
    chk("cnt.B",      32'(B_cnt_o), 32'd2);
    @(negedge aclk);
    areset_n = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1; #1;
    chk("cnt.midrst_A", 32'(A_cnt_o), 32'd0);
    chk("cnt.midrst_B", 32'(B_cnt_o), 32'd0);
    chk("cnt.midrst_B_valid", 32'(B_valid_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
